// File: rtl/packet_fifo.sv
// Store-and-forward packet buffer: a packet is released downstream only once its
// last word is stored, so every released packet streams without valid gaps.
module packet_fifo #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    last_in,
  input  logic [P_DATA_WIDTH-1:0] data_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic                    last_out,
  output logic [P_DATA_WIDTH-1:0] data_out,
  input  logic                    ready_out,
  output logic                    drop_out
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_DEPTH = PW'(P_DEPTH);

  typedef enum logic {
    FILL,
    DISCARD
  } state_t;

  // Each entry carries the word plus its last flag.
  logic [P_DATA_WIDTH:0] mem [P_DEPTH];

  state_t                state_reg, state_next;
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         commit_ptr_reg, commit_ptr_next;
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         occupancy;
  logic                  full;
  logic                  mem_we;
  logic                  drop_next;
  logic                  drop_reg;
  logic                  valid_out_reg;
  logic                  last_out_reg;
  logic [P_DATA_WIDTH-1:0] data_out_reg;
  logic                  out_load;
  logic [P_DATA_WIDTH:0] rd_word;

  assign ready_in  = ~rst;
  assign valid_out = valid_out_reg;
  assign last_out  = last_out_reg;
  assign data_out  = data_out_reg;
  assign drop_out  = drop_reg;

  // Space freed by a same-cycle read is deliberately not visible to this cycle's write.
  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign full      = (occupancy == PTR_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FILL;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      drop_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      drop_reg       <= drop_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    drop_next       = 1'b0;
    mem_we          = 1'b0;
    case (state_reg)
      FILL: begin
        if (valid_in) begin
          if (!full) begin
            mem_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (last_in) begin
              commit_ptr_next = wr_ptr_reg + PTR_ONE;
            end
          end else begin
            // Overflow: throw away the partial packet and skip the rest of it.
            wr_ptr_next = commit_ptr_reg;
            if (last_in) begin
              drop_next = 1'b1;
            end else begin
              state_next = DISCARD;
            end
          end
        end
      end
      DISCARD: begin
        if (valid_in && last_in) begin
          state_next = FILL;
          drop_next  = 1'b1;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_reg[AW-1:0]] <= {last_in, data_in};
    end
  end

  // Only committed words are ever read, which is what guarantees continuity.
  assign rd_word  = mem[rd_ptr_reg[AW-1:0]];
  assign out_load = (rd_ptr_reg != commit_ptr_reg) && (!valid_out_reg || ready_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg    <= '0;
      valid_out_reg <= 1'b0;
      last_out_reg  <= 1'b0;
      data_out_reg  <= '0;
    end else if (out_load) begin
      rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
      valid_out_reg <= 1'b1;
      last_out_reg  <= rd_word[P_DATA_WIDTH];
      data_out_reg  <= rd_word[P_DATA_WIDTH-1:0];
    end else if (valid_out_reg && ready_out) begin
      valid_out_reg <= 1'b0;
    end
  end

endmodule
